// File: rtl/vote_session_controller.sv
// Ballot sequencer for the voting machine: arms one ballot, accepts one qualified
// vote, tallies it with saturation, holds a lockout/acknowledge window, and presents tallies in result mode.
module vote_session_controller #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 100000000,
  parameter int SEL_W       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                arm,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] vote_valid,
  input  logic [SEL_W-1:0]    result_sel,
  output logic                armed,
  output logic                vote_done,
  output logic                conflict,
  output logic [NUM_CAND-1:0] vote_led,
  output logic [CNT_W-1:0]    result_count
);

  localparam int LCW = $clog2(LOCK_CYCLES);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_LOCKOUT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LCW-1:0]   lock_cnt;
  logic [CNT_W-1:0] tally [NUM_CAND];
  logic [CNT_W-1:0] sel_tally;
  logic             single_vote;
  logic             multi_vote;
  logic             accept_vote;
  logic             reject_vote;
  logic             lock_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  always_comb begin
    multi_vote  = |(vote_valid & (vote_valid - NUM_CAND'(1)));
    single_vote = (|vote_valid) && !multi_vote;
    lock_done   = (lock_cnt == LOCK_LAST);
  end

  always_comb begin
    sel_tally = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (result_sel == SEL_W'(i)) sel_tally = tally[i];
    end
  end

  always_comb begin
    state_nxt   = state;
    armed       = 1'b0;
    accept_vote = 1'b0;
    reject_vote = 1'b0;
    case (state)
      S_IDLE: begin
        if (!mode && arm) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        armed = 1'b1;
        // Switching to result mode cancels the ballot even if a vote arrives together with it.
        if (mode) begin
          state_nxt = S_IDLE;
        end else if (single_vote) begin
          accept_vote = 1'b1;
          state_nxt   = S_LOCKOUT;
        end else if (multi_vote) begin
          reject_vote = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (lock_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_cnt <= '0;
    end else if (state == S_LOCKOUT && !lock_done) begin
      lock_cnt <= lock_cnt + LCW'(1);
    end else begin
      lock_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vote_done <= 1'b0;
      conflict  <= 1'b0;
      vote_led  <= '0;
    end else begin
      vote_done <= accept_vote;
      conflict  <= reject_vote;
      if (accept_vote) begin
        vote_led <= vote_valid;
      end else if (state == S_LOCKOUT && lock_done) begin
        vote_led <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else if (accept_vote) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (vote_valid[i]) tally[i] <= sat_inc(tally[i]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    result_count <= '0;
    else if (mode) result_count <= sel_tally;
    else           result_count <= '0;
  end

endmodule

// File: tb/tb_vote_session_controller.sv
// Directed self-checking bench for vote_session_controller (4 candidates,
// 3-bit tallies, 16-cycle lockout).
module tb_vote_session_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] vote_valid = '0;
  logic [1:0] result_sel = '0;
  logic       armed;
  logic       vote_done;
  logic       conflict;
  logic [3:0] vote_led;
  logic [2:0] result_count;

  int total = 0;
  int bad = 0;

  vote_session_controller #(
    .NUM_CAND(4),
    .CNT_W(3),
    .LOCK_CYCLES(16),
    .SEL_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .arm(arm),
    .mode(mode),
    .vote_valid(vote_valid),
    .result_sel(result_sel),
    .armed(armed),
    .vote_done(vote_done),
    .conflict(conflict),
    .vote_led(vote_led),
    .result_count(result_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    arm = 0; mode = 0; vote_valid = '0; result_sel = '0;
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic wait_idle(output bit ok);
    for (int g = 0; g < 40 && vote_led != 4'b0000; g++) tick();
    ok = (vote_led == 4'b0000);
  endtask

  task automatic do_ballot(input logic [3:0] v, output bit done_seen, output bit ended);
    arm = 1;
    tick();
    arm = 0;
    vote_valid = v;
    tick();
    vote_valid = '0;
    done_seen = vote_done;
    wait_idle(ended);
  endtask

  task automatic test_reset();
    reset = 0; mode = 1; result_sel = 2'd1;
    tick();
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%b exp=0", armed); end
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL reset_vote_done got=%b exp=0", vote_done); end
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
    total++; if (vote_led !== 4'b0000) begin bad++; $display("FAIL reset_vote_led got=%b exp=0000", vote_led); end
    total++; if (result_count !== 3'd0) begin bad++; $display("FAIL reset_result got=%0d exp=0", result_count); end
    apply_reset();
  endtask

  task automatic test_basic_vote();
    int led_cycles;
    apply_reset();
    arm = 1;
    tick();
    arm = 0;
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL basic_armed got=%b exp=1", armed); end
    vote_valid = 4'b0010;
    tick();
    vote_valid = '0;
    total++; if (vote_done !== 1'b1) begin bad++; $display("FAIL basic_vote_done got=%b exp=1", vote_done); end
    total++; if (vote_led !== 4'b0010) begin bad++; $display("FAIL basic_vote_led got=%b exp=0010", vote_led); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL basic_armed_lockout got=%b exp=0", armed); end
    led_cycles = 1;
    tick();
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", vote_done); end
    for (int g = 0; g < 40 && vote_led == 4'b0010; g++) begin
      led_cycles++;
      tick();
    end
    total++; if (led_cycles !== 16) begin bad++; $display("FAIL basic_led_cycles got=%0d exp=16", led_cycles); end
    total++; if (vote_led !== 4'b0000) begin bad++; $display("FAIL basic_led_clear got=%b exp=0000", vote_led); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL basic_idle_armed got=%b exp=0", armed); end
    mode = 1; result_sel = 2'd1;
    tick();
    total++; if (result_count !== 3'd1) begin bad++; $display("FAIL basic_tally1 got=%0d exp=1", result_count); end
    mode = 0;
    tick();
    total++; if (result_count !== 3'd0) begin bad++; $display("FAIL basic_vote_mode_result got=%0d exp=0", result_count); end
  endtask

  task automatic test_conflict();
    bit ok;
    apply_reset();
    arm = 1;
    tick();
    arm = 0;
    vote_valid = 4'b0101;
    tick();
    vote_valid = '0;
    total++; if (conflict !== 1'b1) begin bad++; $display("FAIL conflict_pulse got=%b exp=1", conflict); end
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL conflict_no_done got=%b exp=0", vote_done); end
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL conflict_still_armed got=%b exp=1", armed); end
    tick();
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL conflict_width got=%b exp=0", conflict); end
    vote_valid = 4'b0100;
    tick();
    vote_valid = '0;
    total++; if (vote_done !== 1'b1) begin bad++; $display("FAIL conflict_retry_done got=%b exp=1", vote_done); end
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL conflict_retry_noconf got=%b exp=0", conflict); end
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL conflict_lockout_timeout got=%b exp=1", ok); end
    mode = 1; result_sel = 2'd2;
    tick();
    total++; if (result_count !== 3'd1) begin bad++; $display("FAIL conflict_tally2 got=%0d exp=1", result_count); end
    result_sel = 2'd0;
    tick();
    total++; if (result_count !== 3'd0) begin bad++; $display("FAIL conflict_tally0 got=%0d exp=0", result_count); end
    mode = 0;
    tick();
  endtask

  task automatic test_ignored();
    bit ok;
    apply_reset();
    vote_valid = 4'b0001;
    tick();
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL idle_vote_done got=%b exp=0", vote_done); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL idle_armed got=%b exp=0", armed); end
    vote_valid = 4'b0011;
    tick();
    vote_valid = '0;
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL idle_conflict got=%b exp=0", conflict); end
    arm = 1;
    tick();
    arm = 0;
    vote_valid = 4'b1000;
    tick();
    vote_valid = '0;
    tick();
    tick();
    vote_valid = 4'b0001;
    tick();
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL lockout_vote_done got=%b exp=0", vote_done); end
    vote_valid = 4'b0101; arm = 1;
    tick();
    vote_valid = '0; arm = 0;
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL lockout_conflict got=%b exp=0", conflict); end
    total++; if (vote_led !== 4'b1000) begin bad++; $display("FAIL lockout_led_held got=%b exp=1000", vote_led); end
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ignored_lockout_timeout got=%b exp=1", ok); end
    mode = 1; result_sel = 2'd0;
    tick();
    total++; if (result_count !== 3'd0) begin bad++; $display("FAIL ignored_tally0 got=%0d exp=0", result_count); end
    result_sel = 2'd3;
    tick();
    total++; if (result_count !== 3'd1) begin bad++; $display("FAIL ignored_tally3 got=%0d exp=1", result_count); end
    mode = 0;
    tick();
  endtask

  task automatic test_saturation();
    bit done_seen, ended;
    apply_reset();
    for (int n = 1; n <= 9; n++) begin
      do_ballot(4'b0001, done_seen, ended);
      total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL sat_done vote=%0d got=%b exp=1", n, done_seen); end
      total++; if (ended !== 1'b1) begin bad++; $display("FAIL sat_lockout vote=%0d got=%b exp=1", n, ended); end
    end
    mode = 1; result_sel = 2'd0;
    tick();
    total++; if (result_count !== 3'd7) begin bad++; $display("FAIL sat_tally0 got=%0d exp=7", result_count); end
    mode = 0;
    tick();
  endtask

  task automatic test_result_mode();
    bit done_seen, ended;
    apply_reset();
    for (int n = 0; n < 3; n++) do_ballot(4'b1000, done_seen, ended);
    do_ballot(4'b0001, done_seen, ended);
    total++; if (ended !== 1'b1) begin bad++; $display("FAIL result_setup_timeout got=%b exp=1", ended); end
    mode = 1; result_sel = 2'd3;
    tick();
    total++; if (result_count !== 3'd3) begin bad++; $display("FAIL result_sel3 got=%0d exp=3", result_count); end
    result_sel = 2'd0;
    tick();
    total++; if (result_count !== 3'd1) begin bad++; $display("FAIL result_sel0 got=%0d exp=1", result_count); end
    result_sel = 2'd2;
    tick();
    total++; if (result_count !== 3'd0) begin bad++; $display("FAIL result_sel2 got=%0d exp=0", result_count); end
    mode = 0;
    tick();
    total++; if (result_count !== 3'd0) begin bad++; $display("FAIL result_back_voting got=%0d exp=0", result_count); end
    arm = 1;
    tick();
    arm = 0;
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL modewin_armed got=%b exp=1", armed); end
    mode = 1; vote_valid = 4'b0001; result_sel = 2'd0;
    tick();
    vote_valid = '0;
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL modewin_disarm got=%b exp=0", armed); end
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL modewin_no_done got=%b exp=0", vote_done); end
    total++; if (vote_led !== 4'b0000) begin bad++; $display("FAIL modewin_no_led got=%b exp=0000", vote_led); end
    tick();
    total++; if (result_count !== 3'd1) begin bad++; $display("FAIL modewin_tally0 got=%0d exp=1", result_count); end
    mode = 0;
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    arm = 1;
    tick();
    arm = 0;
    vote_valid = 4'b0100;
    tick();
    vote_valid = '0;
    total++; if (vote_done !== 1'b1) begin bad++; $display("FAIL areset_setup_done got=%b exp=1", vote_done); end
    #2;
    reset = 0;
    #1;
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL areset_vote_done got=%b exp=0", vote_done); end
    total++; if (vote_led !== 4'b0000) begin bad++; $display("FAIL areset_vote_led got=%b exp=0000", vote_led); end
    tick();
    reset = 1;
    tick();
    mode = 1; result_sel = 2'd2;
    tick();
    total++; if (result_count !== 3'd0) begin bad++; $display("FAIL areset_tally2 got=%0d exp=0", result_count); end
    mode = 0;
    tick();
    apply_reset();
    arm = 1;
    tick();
    vote_valid = 4'b0100;
    tick();
    tick();
    tick();
    #2;
    reset = 0;
    #1;
    arm = 0;
    vote_valid = '0;
    total++; if (vote_led !== 4'b0000) begin bad++; $display("FAIL areset_mid_lock_led got=%b exp=0000", vote_led); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL areset_mid_lock_armed got=%b exp=0", armed); end
    tick();
    reset = 1;
    tick();
    vote_valid = 4'b0100;
    tick();
    vote_valid = '0;
    total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL areset_needs_arm got=%b exp=0", vote_done); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL areset_not_armed got=%b exp=0", armed); end
    arm = 1;
    tick();
    arm = 0;
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL areset_rearm got=%b exp=1", armed); end
    mode = 1;
    tick();
    mode = 0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    arm = 1;
    tick();
    vote_valid = 4'b0010;
    tick();
    vote_valid = '0;
    total++; if (vote_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", vote_done); end
    for (int g = 0; g < 40 && vote_led != 4'b0000; g++) begin
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL b2b_armed_in_lockout got=%b exp=0", armed); end
      tick();
    end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL b2b_idle_cycle got=%b exp=0", armed); end
    tick();
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL b2b_rearm got=%b exp=1", armed); end
    arm = 0;
    mode = 1;
    tick();
    mode = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_conflict();
    test_ignored();
    test_saturation();
    test_result_mode();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
